// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns unit with a valid/ready handshake.
// Transforms COLS_PER_CYCLE columns per clock, finishing a 128-bit state in
// 4/COLS_PER_CYCLE cycles, then holds the result until the consumer takes it.
module mix_columns_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iValid,
   output logic         oReady,
   input  logic         iInv,
   input  logic [127:0] iData,
   output logic         oValid,
   input  logic         iReady,
   output logic [127:0] oData
);

   localparam int unsigned N    = 4 / COLS_PER_CYCLE;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [127:0]      w_q, w_d;
   logic              m_q, m_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              accept;
   int unsigned       col_idx;

   // Multiply by 02 in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One column through the forward or inverse matrix; byte r of the column
   // sits at col[8*r +: 8].
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] a  [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      logic [7:0] m4 [4];
      logic [7:0] m8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[8*i +: 8];
         m2[i] = xtime(a[i]);
         m4[i] = xtime(m2[i]);
         m8[i] = xtime(m4[i]);
         m3[i] = m2[i] ^ a[i];
         m9[i] = m8[i] ^ a[i];
         mb[i] = m8[i] ^ m2[i] ^ a[i];
         md[i] = m8[i] ^ m4[i] ^ a[i];
         me[i] = m8[i] ^ m4[i] ^ m2[i];
      end
      if (inv) begin
         res[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         res[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         res[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         res[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end else begin
         res[7:0]   = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
         res[15:8]  = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
         res[23:16] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
         res[31:24] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
      end
      return res;
   endfunction

   // Handshake outputs; ready is forced low while reset is asserted.
   always_comb begin
      oValid = (state_q == StDone);
      oData  = w_q;
      oReady = !iRst && ((state_q == StIdle) || ((state_q == StDone) && iReady));
      accept = iValid && oReady;
   end

   // Next-state: accept loads W, RUN transforms one column group per cycle.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      col_idx = 0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               w_d     = iData;
               m_d     = iInv;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
               col_idx = int'(cnt_q) * COLS_PER_CYCLE + g;
               w_d[32*col_idx +: 32] = mix_col(w_q[32*col_idx +: 32], m_q);
            end
            if (cnt_q == CntW'(N - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            if (iReady) begin
               if (accept) begin
                  // Hand off and take the next state on the same edge.
                  w_d     = iData;
                  m_d     = iInv;
                  cnt_d   = '0;
                  state_d = StRun;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= StIdle;
         w_q     <= '0;
         m_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench: three instances (1, 2 and 4 columns per cycle) driven
// with directed vectors, backpressure, back-to-back traffic and mid-run reset.
module tb_mix_columns_iter;

   logic               clk;
   logic               rst;
   logic [2:0]         valid;
   logic [2:0]         inv;
   logic [2:0]         rdy;
   logic [2:0][127:0]  data;
   logic [2:0]         oready;
   logic [2:0]         ovalid;
   logic [2:0][127:0]  odata;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] FwdIn  = 128'h4c31262d_01010101_5c220af2_455313db;
   localparam logic [127:0] FwdOut = 128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e;
   localparam logic [127:0] BndIn  = 128'hd5d4d4d4_00000000_00000000_00000000;
   localparam logic [127:0] BndOut = 128'hd6d7d5d5_00000000_00000000_00000000;
   localparam logic [127:0] AllC6  = {16{8'hc6}};

   for (genvar k = 0; k < 3; k++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
         .iClk   (clk),
         .iRst   (rst),
         .iValid (valid[k]),
         .oReady (oready[k]),
         .iInv   (inv[k]),
         .iData  (data[k]),
         .oValid (ovalid[k]),
         .iReady (rdy[k]),
         .oData  (odata[k])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] coef(input logic iv, input int r, input int j);
      int d;
      d = (j - r + 4) % 4;
      case (d)
         0:       return iv ? 8'h0e : 8'h02;
         1:       return iv ? 8'h0b : 8'h03;
         2:       return iv ? 8'h0d : 8'h01;
         default: return iv ? 8'h09 : 8'h01;
      endcase
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
      logic [127:0] o;
      logic [7:0]   acc;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef(iv, r, j), s[8*(4*c+j) +: 8]);
            o[8*(4*c+r) +: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One transaction on instance k: accept, scramble inputs during RUN,
   // measure latency, hold backpressure for bp cycles, then hand off.
   task automatic run_block(input int k, input logic [127:0] d, input logic iv,
                            input logic [127:0] exp, input int bp, input string tag);
      int lat;
      int nexp;
      nexp = 4 >> k;
      @(posedge clk); #1;
      check({tag, "_ready_idle"}, 128'(oready[k]), 128'd1);
      data[k] = d; inv[k] = iv; valid[k] = 1'b1; rdy[k] = 1'b0;
      @(posedge clk); #1;
      valid[k] = 1'b0; data[k] = ~d; inv[k] = ~iv;
      check({tag, "_ready_run"}, 128'(oready[k]), 128'd0);
      lat = 0;
      while (!ovalid[k] && lat < 20) begin
         @(posedge clk); #1;
         data[k] = rand128(); valid[k] = lat[0]; inv[k] = ~inv[k];
         lat++;
      end
      valid[k] = 1'b0;
      check({tag, "_latency"}, 128'(lat), 128'(nexp));
      check({tag, "_data"}, odata[k], exp);
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         data[k] = rand128(); inv[k] = ~inv[k]; valid[k] = i[0];
         check({tag, "_bp_data"}, odata[k], exp);
         check({tag, "_bp_valid"}, 128'(ovalid[k]), 128'd1);
         check({tag, "_bp_ready"}, 128'(oready[k]), 128'd0);
      end
      valid[k] = 1'b0;
      rdy[k] = 1'b1;
      #1 check({tag, "_ready_done"}, 128'(oready[k]), 128'd1);
      @(posedge clk); #1;
      rdy[k] = 1'b0;
      check({tag, "_valid_after"}, 128'(ovalid[k]), 128'd0);
   endtask

   // Back-to-back stream with valid and ready held high, alternating mode.
   task automatic run_b2b(input int k, input int nb);
      logic [127:0] blk;
      logic [127:0] exp_q[$];
      int           sent;
      int           got;
      logic         acc;
      sent = 0;
      got  = 0;
      @(posedge clk); #1;
      blk = rand128();
      data[k] = blk; inv[k] = 1'b0; valid[k] = 1'b1; rdy[k] = 1'b1;
      exp_q.push_back(model(blk, 1'b0));
      acc = oready[k];
      for (int cyc = 0; cyc < nb * 8 && got < nb; cyc++) begin
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            if (sent < nb) begin
               blk = rand128();
               data[k] = blk; inv[k] = sent[0];
               exp_q.push_back(model(blk, sent[0]));
            end else begin
               valid[k] = 1'b0;
            end
         end
         if (ovalid[k]) begin
            check($sformatf("b2b%0d_data_%0d", k, got), odata[k], exp_q[got]);
            if (valid[k]) check($sformatf("b2b%0d_ready_%0d", k, got), 128'(oready[k]), 128'd1);
            got++;
         end
         acc = oready[k] && valid[k];
      end
      check($sformatf("b2b%0d_count", k), 128'(got), 128'(nb));
      valid[k] = 1'b0;
      @(posedge clk); #1;
      rdy[k] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = '0; inv = '0; rdy = '0; data = '0;
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst%0d_valid", k), 128'(ovalid[k]), 128'd0);
         check($sformatf("rst%0d_ready", k), 128'(oready[k]), 128'd0);
         check($sformatf("rst%0d_data", k), odata[k], 128'd0);
      end
      rst = 1'b0;

      run_block(0, FwdIn, 1'b0, FwdOut, 10, "fwd1");
      run_block(1, FwdOut, 1'b1, FwdIn, 0, "inv2");
      run_block(2, FwdOut, 1'b1, FwdIn, 0, "inv4");
      run_block(0, BndIn, 1'b0, BndOut, 0, "bnd1");
      run_block(1, BndIn, 1'b0, BndOut, 0, "bnd2");
      run_block(2, BndIn, 1'b0, BndOut, 0, "bnd4");
      run_block(0, BndOut, 1'b1, BndIn, 0, "bndinv1");
      run_block(2, AllC6, 1'b1, AllC6, 0, "c6inv4");

      for (int k = 0; k < 3; k++) run_b2b(k, 200);

      // Reset while instance 0 is mid-RUN.
      @(posedge clk); #1;
      data[0] = FwdIn; inv[0] = 1'b0; valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", 128'(ovalid[0]), 128'd0);
      check("midrst_ready", 128'(oready[0]), 128'd0);
      check("midrst_data", odata[0], 128'd0);
      @(posedge clk); #1;
      check("midrst_valid_hold", 128'(ovalid[0]), 128'd0);
      rst = 1'b0;
      run_block(0, AllC6, 1'b0, AllC6, 0, "c6fwd1");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
